alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation runs at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold response).
module alu_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req0_op,
   input  logic [1:0]       req1_op,
   output logic [1:0]       req_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   input  logic             rsp_ready
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic             gid_q, gid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic             last_grant_q, last_grant_d;

   logic grant_en;
   logic grant_id;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_id = 1'b0;
      case (req_valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant_q;
         default: grant_id = 1'b0;
      endcase
      // Gated by rst_n so ready stays low while reset is held.
      grant_en  = rst_n && (state_q == StIdle) && (|req_valid);
      req_ready = grant_en ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      gid_d        = gid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         StIdle: begin
            if (grant_en) begin
               a_d     = grant_id ? req1_a  : req0_a;
               b_d     = grant_id ? req1_b  : req0_b;
               op_d    = grant_id ? req1_op : req0_op;
               gid_d   = grant_id;
               state_d = StExec;
            end
         end
         StExec: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_id_d     = gid_q;
            state_d      = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               last_grant_d = rsp_id_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 2'b00;
         gid_q        <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 4'b0000;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         gid_q        <= gid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;

endmodule
